// File: rtl/custom_alu_pkg.sv
// Shared types and defaults for the custom ALU issuer
// and the datapath it drives.
package custom_alu_pkg;

   localparam int ALU_XLEN = 32;
   localparam int ALU_OPW  = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } alu_iss_state_e;

endpackage

// File: rtl/custom_alu_issuer.sv
// Command/response front end for the combinational custom ALU:
// latches operands, waits a settle time, returns the result with its tag.
module custom_alu_issuer
   import custom_alu_pkg::*;
#(
   parameter int XLEN          = ALU_XLEN,
   parameter int OPW           = ALU_OPW,
   parameter int TAGW          = 4,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic [XLEN-1:0] cmd_op_a,
   input  logic [XLEN-1:0] cmd_op_b,
   input  logic [OPW-1:0]  cmd_op_code,
   input  logic [TAGW-1:0] cmd_tag,
   output logic [XLEN-1:0] alu_op_a,
   output logic [XLEN-1:0] alu_op_b,
   output logic [OPW-1:0]  alu_op_code,
   input  logic [XLEN-1:0] alu_result,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [XLEN-1:0] rsp_result,
   output logic [TAGW-1:0] rsp_tag,
   output logic            busy,
   output logic [15:0]     ops_done
);

   generate
      if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
         $error("custom_alu_issuer: SETTLE_CYCLES must be 1..15");
      end
   endgenerate

   alu_iss_state_e state;
   alu_iss_state_e state_nxt;
   logic [3:0]     settle_cnt;
   logic [15:0]    done_cnt;
   logic           accept;
   logic           capture;
   logic           retire;

   assign cmd_ready = resetn &&
                      (state == IDLE || (state == RESP && rsp_ready));
   assign accept    = cmd_valid && cmd_ready;
   assign capture   = (state == WAIT) && (settle_cnt == 4'd1);
   assign retire    = (state == RESP) && rsp_ready;
   assign busy      = (state != IDLE);
   assign ops_done  = done_cnt;

   always_ff @(posedge clk) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (accept) state_nxt = WAIT;
         WAIT: if (capture) state_nxt = RESP;
         RESP: if (retire) state_nxt = accept ? WAIT : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // A retire and a new accept may land on the same edge; the
   // operand/tag load and the rsp_valid drop then happen together.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         alu_op_a    <= '0;
         alu_op_b    <= '0;
         alu_op_code <= '0;
         rsp_tag     <= '0;
         rsp_result  <= '0;
         rsp_valid   <= 1'b0;
         settle_cnt  <= '0;
         done_cnt    <= '0;
      end else begin
         if (accept) begin
            alu_op_a    <= cmd_op_a;
            alu_op_b    <= cmd_op_b;
            alu_op_code <= cmd_op_code;
            rsp_tag     <= cmd_tag;
            settle_cnt  <= 4'(SETTLE_CYCLES);
         end else if (state == WAIT && !capture) begin
            settle_cnt <= settle_cnt - 4'd1;
         end
         if (capture) begin
            rsp_result <= alu_result;
            rsp_valid  <= 1'b1;
         end else if (retire) begin
            rsp_valid <= 1'b0;
         end
         if (retire) done_cnt <= done_cnt + 16'd1;
      end
   end

endmodule
